// File: rtl/inst_queue.sv
// inst_queue: circular instruction queue between IF and ID.
// Accepts up to two words per cycle from a fetch bundle and presents the
// two oldest entries to ID, which consumes 0..2 of them per cycle.
module inst_queue #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       stall_id,
    input  logic                       in_valid,
    input  logic [31:0]                in_pc,
    input  logic [63:0]                in_inst,
    input  logic [1:0]                 in_mask,
    output logic                       in_ready,
    input  logic [1:0]                 pop_num,
    output logic                       out0_valid,
    output logic                       out1_valid,
    output logic [31:0]                out0_pc,
    output logic [31:0]                out1_pc,
    output logic [31:0]                out0_inst,
    output logic [31:0]                out1_inst,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   inst_mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW-1:0] head_p1;
    logic [AW-1:0] tail_p1;
    logic          push;
    logic [1:0]    push_n;
    logic [1:0]    pop_clamp;
    logic [1:0]    pop_eff;

    // Push/pop amounts for this cycle; flush suppresses both.
    always_comb begin
        push      = in_valid && in_ready && !flush;
        push_n    = 2'd0;
        pop_clamp = (pop_num == 2'd3) ? 2'd2 : pop_num;
        pop_eff   = pop_clamp;
        head_p1   = head + AW'(1);
        tail_p1   = tail + AW'(1);
        if (push) begin
            push_n = {1'b0, in_mask[0]} + {1'b0, in_mask[1]};
        end
        if (stall_id || flush) begin
            pop_eff = 2'd0;
        end else if (CW'(pop_clamp) > count) begin
            pop_eff = count[1:0];
        end
    end

    // Entry storage: low word first, a lone high word lands at tail.
    always_ff @(posedge clk) begin
        if (push) begin
            case (in_mask)
                2'b11: begin
                    pc_mem[tail]      <= in_pc;
                    inst_mem[tail]    <= in_inst[31:0];
                    pc_mem[tail_p1]   <= in_pc + 32'd4;
                    inst_mem[tail_p1] <= in_inst[63:32];
                end
                2'b01: begin
                    pc_mem[tail]   <= in_pc;
                    inst_mem[tail] <= in_inst[31:0];
                end
                2'b10: begin
                    pc_mem[tail]   <= in_pc + 32'd4;
                    inst_mem[tail] <= in_inst[63:32];
                end
                default: ;
            endcase
        end
    end

    // Pointer and occupancy update; flush empties the queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AW'(pop_eff);
            tail  <= tail + AW'(push_n);
            count <= count - CW'(pop_eff) + CW'(push_n);
        end
    end

    // Head-side outputs from registered state, zeroed when not valid.
    always_comb begin
        in_ready   = (count <= CW'(DEPTH - 2));
        out0_valid = (count != '0);
        out1_valid = (count >= CW'(2));
        out0_pc    = out0_valid ? pc_mem[head]      : 32'd0;
        out0_inst  = out0_valid ? inst_mem[head]    : 32'd0;
        out1_pc    = out1_valid ? pc_mem[head_p1]   : 32'd0;
        out1_inst  = out1_valid ? inst_mem[head_p1] : 32'd0;
    end

endmodule

// File: tb/tb_inst_queue.sv
// Testbench for inst_queue: directed scenarios plus a randomized stream
// checked against a queue-based reference model.
module tb_inst_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        stall_id;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [63:0] in_inst;
    logic [1:0]  in_mask;
    logic        in_ready;
    logic [1:0]  pop_num;
    logic        out0_valid, out1_valid;
    logic [31:0] out0_pc, out1_pc, out0_inst, out1_inst;
    logic [3:0]  count;

    int checks   = 0;
    int failures = 0;

    // Reference model: each element is {pc, inst}, oldest at index 0.
    logic [63:0] q[$];

    inst_queue #(.DEPTH(8)) dut (
        .clk(clk), .rst(rst), .flush(flush), .stall_id(stall_id),
        .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
        .in_mask(in_mask), .in_ready(in_ready), .pop_num(pop_num),
        .out0_valid(out0_valid), .out1_valid(out1_valid),
        .out0_pc(out0_pc), .out1_pc(out1_pc),
        .out0_inst(out0_inst), .out1_inst(out1_inst),
        .count(count)
    );

    always #5 clk = ~clk;

    // Advance one clock, updating the model from the inputs seen at the edge.
    task automatic tick();
        int          pcl;
        int          pe;
        bit          rdy;
        bit          fl;
        bit          iv;
        logic [1:0]  m;
        logic [31:0] pc;
        logic [63:0] ins;
        rdy = (8 - q.size()) >= 2;
        pcl = (pop_num == 2'd3) ? 2 : int'(pop_num);
        pe  = (stall_id || flush) ? 0 : ((pcl < q.size()) ? pcl : q.size());
        fl  = flush;
        iv  = in_valid;
        m   = in_mask;
        pc  = in_pc;
        ins = in_inst;
        @(posedge clk);
        if (rst || fl) begin
            q.delete();
        end else begin
            repeat (pe) void'(q.pop_front());
            if (iv && rdy) begin
                if (m[0]) q.push_back({pc, ins[31:0]});
                if (m[1]) q.push_back({pc + 32'd4, ins[63:32]});
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        flush = 0; stall_id = 0; in_valid = 0; in_pc = '0;
        in_inst = '0; in_mask = 2'b00; pop_num = 2'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        #2;
        checks++;
        if ({out0_valid, out1_valid, out0_pc, out1_pc, out0_inst, out1_inst} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: v0=%b v1=%b pc0=%h pc1=%h i0=%h i1=%h, required all zero",
                     out0_valid, out1_valid, out0_pc, out1_pc, out0_inst, out1_inst);
        end
        checks++;
        if (in_ready !== 1'b1 || count !== 4'd0) begin
            failures++;
            $display("FAIL reset_ready_count: in_ready=%b count=%0d, required 1 and 0", in_ready, count);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
    endtask

    task automatic test_basic_push();
        in_valid = 1; in_pc = 32'hBFC0_0000;
        in_inst = {32'h2402_0002, 32'h2401_0001}; in_mask = 2'b11; pop_num = 0;
        #1;
        checks++;
        if (out0_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_no_bypass: out0_valid=%b, required 0", out0_valid);
        end
        tick();
        idle_inputs();
        checks++;
        if (count !== 4'd2) begin
            failures++;
            $display("FAIL basic_count: got %0d, required 2", count);
        end
        checks++;
        if ({out0_valid, out0_pc, out0_inst} !== {1'b1, 32'hBFC0_0000, 32'h2401_0001}) begin
            failures++;
            $display("FAIL basic_out0: v=%b pc=%h inst=%h, required 1 bfc00000 24010001",
                     out0_valid, out0_pc, out0_inst);
        end
        checks++;
        if ({out1_valid, out1_pc, out1_inst} !== {1'b1, 32'hBFC0_0004, 32'h2402_0002}) begin
            failures++;
            $display("FAIL basic_out1: v=%b pc=%h inst=%h, required 1 bfc00004 24020002",
                     out1_valid, out1_pc, out1_inst);
        end
    endtask

    task automatic test_full();
        flush = 1; tick(); idle_inputs();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; in_mask = 2'b11; in_pc = 32'h100 + 32'(i * 8);
            in_inst = {32'hB000_0000 + 32'(i), 32'hA000_0000 + 32'(i)};
            tick();
        end
        checks++;
        if (count !== 4'd8 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_state: count=%0d in_ready=%b, required 8 and 0", count, in_ready);
        end
        in_pc = 32'h500; in_inst = {32'hDEAD_0001, 32'hDEAD_0000};
        tick();
        in_valid = 0;
        checks++;
        if (count !== 4'd8) begin
            failures++;
            $display("FAIL full_ignore_push: count=%0d, required 8", count);
        end
        pop_num = 2;
        tick();
        pop_num = 0;
        checks++;
        if (count !== 4'd6 || in_ready !== 1'b1 || out0_pc !== 32'h108) begin
            failures++;
            $display("FAIL full_after_pop: count=%0d in_ready=%b pc0=%h, required 6 1 00000108",
                     count, in_ready, out0_pc);
        end
    endtask

    task automatic test_mask_high();
        flush = 1; tick(); idle_inputs();
        in_valid = 1; in_mask = 2'b10; in_pc = 32'hBFC0_0010;
        in_inst = {32'h1111_2222, 32'h3333_4444};
        tick();
        idle_inputs();
        checks++;
        if (count !== 4'd1 || out0_pc !== 32'hBFC0_0014 || out0_inst !== 32'h1111_2222
            || out1_valid !== 1'b0) begin
            failures++;
            $display("FAIL mask_high: count=%0d pc0=%h i0=%h v1=%b, required 1 bfc00014 11112222 0",
                     count, out0_pc, out0_inst, out1_valid);
        end
    endtask

    task automatic test_push_pop();
        in_valid = 1; in_mask = 2'b11; in_pc = 32'h200;
        in_inst = {32'h5555_6666, 32'h7777_8888}; pop_num = 2;
        tick();
        idle_inputs();
        checks++;
        if (count !== 4'd2 || out0_pc !== 32'h200 || out0_inst !== 32'h7777_8888) begin
            failures++;
            $display("FAIL push_pop: count=%0d pc0=%h i0=%h, required 2 00000200 77778888",
                     count, out0_pc, out0_inst);
        end
    endtask

    task automatic test_stall_flush();
        flush = 1; tick(); idle_inputs();
        in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            in_mask = (i == 2) ? 2'b01 : 2'b11;
            in_pc = 32'h300 + 32'(i * 8); in_inst = {$urandom, $urandom};
            tick();
        end
        checks++;
        if (count !== 4'd5) begin
            failures++;
            $display("FAIL stall_setup: count=%0d, required 5", count);
        end
        stall_id = 1; pop_num = 2; in_mask = 2'b01; in_pc = 32'h318;
        tick();
        checks++;
        if (count !== 4'd6 || out0_pc !== 32'h300) begin
            failures++;
            $display("FAIL stall_hold: count=%0d pc0=%h, required 6 00000300", count, out0_pc);
        end
        stall_id = 0; flush = 1; in_mask = 2'b11; in_pc = 32'h320;
        tick();
        idle_inputs();
        checks++;
        if (count !== 4'd0 || out0_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_prio: count=%0d v0=%b in_ready=%b, required 0 0 1",
                     count, out0_valid, in_ready);
        end
    endtask

    task automatic test_stream();
        int          nb = 0;
        int          cyc = 0;
        bit          acc;
        logic        e0v, e1v;
        logic [31:0] e0pc, e0i, e1pc, e1i;
        flush = 1; tick(); idle_inputs();
        while ((nb < 20 || q.size() != 0) && cyc < 400) begin
            in_valid = (nb < 20) && ($urandom_range(0, 3) != 0);
            in_mask  = 2'($urandom_range(0, 3));
            in_pc    = 32'h8000_0000 + 32'(nb * 8);
            in_inst  = {$urandom, $urandom};
            pop_num  = 2'($urandom_range(0, 3));
            stall_id = ($urandom_range(0, 4) == 0);
            acc = in_valid && (q.size() <= 6);
            tick();
            cyc++;
            if (acc) nb++;
            e0v  = (q.size() >= 1);
            e1v  = (q.size() >= 2);
            e0pc = e0v ? q[0][63:32] : 32'd0;
            e0i  = e0v ? q[0][31:0]  : 32'd0;
            e1pc = e1v ? q[1][63:32] : 32'd0;
            e1i  = e1v ? q[1][31:0]  : 32'd0;
            checks++;
            if ({out0_valid, out0_pc, out0_inst} !== {e0v, e0pc, e0i}) begin
                failures++;
                $display("FAIL stream_out0 cyc%0d: v=%b pc=%h i=%h, required v=%b pc=%h i=%h",
                         cyc, out0_valid, out0_pc, out0_inst, e0v, e0pc, e0i);
            end
            checks++;
            if ({out1_valid, out1_pc, out1_inst} !== {e1v, e1pc, e1i}) begin
                failures++;
                $display("FAIL stream_out1 cyc%0d: v=%b pc=%h i=%h, required v=%b pc=%h i=%h",
                         cyc, out1_valid, out1_pc, out1_inst, e1v, e1pc, e1i);
            end
            checks++;
            if (count !== 4'(q.size()) || in_ready !== ((8 - q.size()) >= 2)) begin
                failures++;
                $display("FAIL stream_count cyc%0d: count=%0d in_ready=%b, required count=%0d",
                         cyc, count, in_ready, q.size());
            end
        end
        idle_inputs();
        checks++;
        if (cyc >= 400) begin
            failures++;
            $display("FAIL stream_timeout: pushed %0d bundles, %0d left, required 20 and 0", nb, q.size());
        end
    endtask

    task automatic test_mid_reset();
        in_valid = 1; in_mask = 2'b11;
        for (int i = 0; i < 2; i++) begin
            in_pc = 32'h900 + 32'(i * 8); in_inst = {$urandom, $urandom};
            tick();
        end
        pop_num = 1; flush = 0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out0_valid !== 1'b0 || out1_valid !== 1'b0 || count !== 4'd0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset: v0=%b v1=%b count=%0d in_ready=%b, required 0 0 0 1",
                     out0_valid, out1_valid, count, in_ready);
        end
        q.delete();
        tick();
        rst = 1'b0;
        idle_inputs();
        in_valid = 1; in_mask = 2'b11; in_pc = 32'hA00;
        in_inst = {32'hCAFE_0002, 32'hCAFE_0001};
        tick();
        idle_inputs();
        checks++;
        if (count !== 4'd2 || out0_pc !== 32'hA00 || out1_inst !== 32'hCAFE_0002) begin
            failures++;
            $display("FAIL after_reset_push: count=%0d pc0=%h i1=%h, required 2 00000a00 cafe0002",
                     count, out0_pc, out1_inst);
        end
    endtask

    initial begin
        test_reset();
        test_basic_push();
        test_full();
        test_mask_high();
        test_push_pop();
        test_stall_flush();
        test_stream();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 Parameter DEPTH, default 8, meaning number of instruction entries; SHALL be a power of two, at least 4.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 flush  input  1  exception/redirect flush from CTRL; discards all queued entries.
REQ-005 stall_id  input  1  ID stage stalled; pop request ignored while high.
REQ-006 in_valid  input  1  fetch bundle present from IF/inst SRAM.
REQ-007 in_pc  input  32  PC of low word of bundle (8-byte aligned).
REQ-008 in_inst  input  64  fetch bundle; [31:0] at in_pc, [63:32] at in_pc+4.
REQ-009 in_mask  input  2  bit0 low word valid, bit1 high word valid.
REQ-010 in_ready  output  1  queue can accept a full two-word bundle this cycle.
REQ-011 pop_num  input  2  entries consumed by ID this cycle (0, 1, 2; 3 treated as 2).
REQ-012 out0_valid, out1_valid  output  1 each  head and head+1 entries present.
REQ-013 out0_pc, out1_pc  output  32 each  PCs of head, head+1.
REQ-014 out0_inst, out1_inst  output  32 each  instructions of head, head+1.
REQ-015 count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.

Function
REQ-016 Storage SHALL be circular: DEPTH entries of {pc, inst}, head and tail pointers of log2(DEPTH) bits wrapping modulo DEPTH, separate occupancy counter.
REQ-017 in_ready SHALL be (DEPTH - count) >= 2, from registered count only; pop in the same cycle does not raise it (no ready-on-pop bypass).
REQ-018 Push SHALL occur when in_valid && in_ready && !flush; push_n = popcount(in_mask).
REQ-019 Write order SHALL be low word then high word: mask 11 writes low at tail, high at tail+1; mask 01 writes low only; mask 10 writes high (pc = in_pc+4) at tail; mask 00 writes nothing.
REQ-020 pop_eff SHALL be 0 if stall_id or flush, else min(pop_num clamped to 2, count).
REQ-021 Next cycle: head += pop_eff, tail += push_n, count = count - pop_eff + push_n (both modulo/wrap as per REQ-016).
REQ-022 Outputs SHALL be combinational from registered state: out0 = entry[head], valid when count >= 1; out1 = entry[head+1 mod DEPTH], valid when count >= 2; no same-cycle push-to-output bypass (min latency push->out0_valid = 1 cycle).
REQ-023 When outN_valid is 0, outN_pc and outN_inst SHALL be 0.
REQ-024 Simultaneous push and pop SHALL both take effect; entries enqueued this cycle are never popped this cycle.
REQ-025 flush SHALL take priority over push, pop and stall_id: next cycle head = tail = count = 0; in-flight bundle dropped.
REQ-026 count SHALL never exceed DEPTH nor underflow; pop_num greater than count pops only count entries.
REQ-027 Ordering SHALL be strict FIFO by PC arrival order across wrap-around.

Reset
REQ-028 rst high SHALL immediately set head, tail, count to 0; outputs: out0_valid = out1_valid = 0, all pc/inst outputs 0, in_ready = 1, count = 0.
REQ-029 Entry storage need not be reset; REQ-023 masks its contents.
REQ-030 rst asserted mid-operation SHALL discard all entries regardless of flush/push/pop that cycle; first push after deassertion behaves as from empty.

Verification
REQ-031 Reset, then push in_pc=0xBFC00000, in_inst={0x24020002,0x24010001}, mask 11, pop 0 -> next cycle count=2, out0 pc 0xBFC00000 inst 0x24010001, out1 pc 0xBFC00004 inst 0x24020002.
REQ-032 Fill DEPTH=8 with four mask-11 bundles, pop 0 -> count=8, in_ready=0; fifth in_valid bundle ignored; then pop_num=2 one cycle -> count=6, in_ready=1 the following cycle.
REQ-033 Push mask 10 at in_pc=0xBFC00010 into empty queue -> count=1, out0_pc=0xBFC00014, out1_valid=0.
REQ-034 count=1, pop_num=2 with simultaneous mask-11 push -> count=2, out0 = low word of new bundle.
REQ-035 count=5, stall_id=1, pop_num=2, push mask 01 -> count=6; then flush=1 with push and pop -> count=0, out0_valid=0, in_ready=1.
REQ-036 Stream 20 bundles with random masks and pop_num across wrap-around -> output PC/inst sequence matches scoreboard FIFO exactly; assert rst mid-stream -> all valids 0 in same cycle.
